// File: rtl/bist_pkg.sv
// Shared constants, FSM encoding and the fault-free signature reference for the BIST wrapper.
package bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CAPTURE,
      UNLOAD,
      COMPARE,
      DONE
   } bist_state_e;

   localparam int unsigned SCAN_LEN  = 8;
   localparam int unsigned CNT_W     = $clog2(SCAN_LEN);
   localparam int unsigned PAT_W     = 8;

   localparam logic [7:0]  LFSR_SEED = 8'h01;
   localparam logic [7:0]  LFSR_TAPS = 8'hB8;   // bits 7,5,4,3: x^8+x^6+x^5+x^4+1
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'h0000;

   // Fault-free signature of a full run starting from a cleared CUT, evaluated at elaboration.
   function automatic logic [15:0] golden_sig(input int unsigned n_pat);
      logic [7:0]  l;
      logic [15:0] m;
      logic [4:0]  ra;
      logic        lk;
      logic [1:0]  to;
      logic        fz;
      logic        cap;
      logic [4:0]  ra_n;
      logic [1:0]  to_n;
      int unsigned n_bits;
      l  = LFSR_SEED;
      m  = MISR_SEED;
      ra = '0;
      lk = 1'b0;
      to = '0;
      for (int unsigned p = 0; p <= n_pat; p++) begin
         n_bits = (p < n_pat) ? SCAN_LEN + 1 : SCAN_LEN;
         for (int unsigned b = 0; b < n_bits; b++) begin
            cap = (p < n_pat) && (b == SCAN_LEN);
            fz  = ~(l[1] & (ra == 5'd0));
            m   = {m[14:0], 1'b0} ^ (m[15] ? MISR_POLY : 16'h0000)
                  ^ {6'b0, to[1], fz, lk, ra, to};
            if (cap) begin
               to_n = l[4:3] ^ {ra[4], ra[0]};
               ra_n = l[1] ? (l[0] ? ra + 5'd1 : ra - 5'd1) : ra;
               lk   = lk ^ l[2];
               to   = to_n;
               ra   = ra_n;
            end else begin
               to = {to[0], lk};
               lk = ra[4];
               ra = {ra[3:0], l[7]};
            end
            l = {l[6:0], ^(l & LFSR_TAPS)};
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/bist_cut.sv
// Scan-equipped circuit-under-test: 8-flop chain, functional next-state logic and fz_L decode.
// BIST_FAULT_INJECT_EN forces the lclk flop output stuck-at-0.
module bist_cut
   import bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       scan_en,
   input  logic       scan_in,
   input  logic       s,
   input  logic       dv,
   input  logic       l_in,
   input  logic [1:0] test_in,
   output logic [4:0] read_a,
   output logic       lclk,
   output logic [1:0] test_out,
   output logic       fz_L,
   output logic       scan_out
);

   logic [4:0] read_a_q, read_a_d;
   logic       lclk_q, lclk_d;
   logic [1:0] test_out_q, test_out_d;

`ifdef BIST_FAULT_INJECT_EN
   assign lclk = 1'b0;
`else
   assign lclk = lclk_q;
`endif

   assign read_a   = read_a_q;
   assign test_out = test_out_q;
   assign fz_L     = ~(dv & (read_a_q == 5'd0));
   assign scan_out = test_out_q[1];

   always_comb begin
      read_a_d   = read_a_q;
      lclk_d     = lclk_q;
      test_out_d = test_out_q;
      if (clr) begin
         read_a_d   = '0;
         lclk_d     = 1'b0;
         test_out_d = '0;
      end else if (en) begin
         if (scan_en) begin
            // chain order: scan_in -> read_a[0..4] -> lclk -> test_out[0] -> test_out[1]
            read_a_d   = {read_a_q[3:0], scan_in};
            lclk_d     = read_a_q[4];
            test_out_d = {test_out_q[0], lclk};
         end else begin
            if (dv) begin
               read_a_d = s ? read_a_q + 5'd1 : read_a_q - 5'd1;
            end
            lclk_d     = lclk_q ^ l_in;
            test_out_d = test_in ^ {read_a_q[4], read_a_q[0]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_a_q   <= '0;
         lclk_q     <= 1'b0;
         test_out_q <= '0;
      end else begin
         read_a_q   <= read_a_d;
         lclk_q     <= lclk_d;
         test_out_q <= test_out_d;
      end
   end

endmodule

// File: rtl/bist_top.sv
// Chip-level BIST wrapper: controller FSM, LFSR pattern source, MISR compactor and CUT input muxing.
// BIST_FAULT_INJECT_EN (see bist_cut) makes the run fail against the default golden signature.
module bist_top
   import bist_pkg::*;
#(
   parameter int unsigned N_PATTERNS = 32,
   parameter logic [15:0] GOLDEN_SIG = golden_sig(N_PATTERNS)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       bist_start,
   input  logic       s,
   input  logic       dv,
   input  logic       l_in,
   input  logic [1:0] test_in,
   output logic       pass_nfail,
   output logic       bist_end,
   output logic       cut_fz_L,
   output logic       cut_lclk,
   output logic [4:0] cut_read_a,
   output logic [1:0] cut_test_out
);

   bist_state_e      state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [15:0]      misr_q, misr_d;
   logic             pass_q, pass_d;
   logic             end_q, end_d;

   logic       bist_mode;
   logic       step;
   logic       scan_en;
   logic       cut_en;
   logic       cut_clr;
   logic       cut_scan_out;
   logic       cut_s, cut_dv, cut_l_in;
   logic [1:0] cut_test_in;

   assign bist_mode = state_q inside {SHIFT, CAPTURE, UNLOAD, COMPARE};
   assign step      = state_q inside {SHIFT, CAPTURE, UNLOAD};
   assign scan_en   = state_q inside {SHIFT, UNLOAD};
   // CUT is frozen in COMPARE so it keeps the last unloaded chain content;
   // it is cleared on start so every run begins from the same state.
   assign cut_en    = (state_q != COMPARE);
   assign cut_clr   = (state_q == IDLE) && bist_start;

   assign cut_s       = bist_mode ? lfsr_q[0]   : s;
   assign cut_dv      = bist_mode ? lfsr_q[1]   : dv;
   assign cut_l_in    = bist_mode ? lfsr_q[2]   : l_in;
   assign cut_test_in = bist_mode ? lfsr_q[4:3] : test_in;

   assign pass_nfail = pass_q;
   assign bist_end   = end_q;

   bist_cut u_cut (
      .clk      (clock),
      .rst_n    (reset),
      .clr      (cut_clr),
      .en       (cut_en),
      .scan_en  (scan_en),
      .scan_in  (lfsr_q[7]),
      .s        (cut_s),
      .dv       (cut_dv),
      .l_in     (cut_l_in),
      .test_in  (cut_test_in),
      .read_a   (cut_read_a),
      .lclk     (cut_lclk),
      .test_out (cut_test_out),
      .fz_L     (cut_fz_L),
      .scan_out (cut_scan_out)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      pat_cnt_d = pat_cnt_q;
      lfsr_d    = lfsr_q;
      misr_d    = misr_q;
      pass_d    = pass_q;
      end_d     = end_q;

      if (step) begin
         lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
         misr_d = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? MISR_POLY : 16'h0000)
                  ^ {6'b0, cut_scan_out, cut_fz_L, cut_lclk, cut_read_a, cut_test_out};
      end

      case (state_q)
         IDLE: begin
            if (bist_start) begin
               state_d   = SHIFT;
               lfsr_d    = LFSR_SEED;
               misr_d    = MISR_SEED;
               bit_cnt_d = '0;
               pat_cnt_d = '0;
               pass_d    = 1'b0;
               end_d     = 1'b0;
            end
         end
         SHIFT: begin
            if (bit_cnt_q == CNT_W'(SCAN_LEN - 1)) begin
               bit_cnt_d = '0;
               state_d   = CAPTURE;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         CAPTURE: begin
            if (pat_cnt_q == PAT_W'(N_PATTERNS - 1)) begin
               state_d = UNLOAD;
            end else begin
               pat_cnt_d = pat_cnt_q + 1'b1;
               state_d   = SHIFT;
            end
         end
         UNLOAD: begin
            if (bit_cnt_q == CNT_W'(SCAN_LEN - 1)) begin
               bit_cnt_d = '0;
               state_d   = COMPARE;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         COMPARE: begin
            pass_d  = (misr_q == GOLDEN_SIG);
            end_d   = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (!bist_start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         pat_cnt_q <= '0;
         lfsr_q    <= '0;
         misr_q    <= '0;
         pass_q    <= 1'b0;
         end_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         pat_cnt_q <= pat_cnt_d;
         lfsr_q    <= lfsr_d;
         misr_q    <= misr_d;
         pass_q    <= pass_d;
         end_q     <= end_d;
      end
   end

endmodule

// File: tb/tb_bist_top.sv
// Scoreboard bench for bist_top: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_bist_top;

   localparam int unsigned N     = 32;
   localparam int unsigned TOTAL = 9 * N + 8;
`ifdef BIST_FAULT_INJECT_EN
   localparam bit FAULT = 1'b1;
`else
   localparam bit FAULT = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       bist_start;
   logic       s, dv, l_in;
   logic [1:0] test_in;
   logic       pass_nfail, bist_end, cut_fz_L, cut_lclk;
   logic [4:0] cut_read_a;
   logic [1:0] cut_test_out;

   bist_top dut (
      .clock        (clock),
      .reset        (reset),
      .bist_start   (bist_start),
      .s            (s),
      .dv           (dv),
      .l_in         (l_in),
      .test_in      (test_in),
      .pass_nfail   (pass_nfail),
      .bist_end     (bist_end),
      .cut_fz_L     (cut_fz_L),
      .cut_lclk     (cut_lclk),
      .cut_read_a   (cut_read_a),
      .cut_test_out (cut_test_out)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // mask bits: 0 read_a, 1 lclk, 2 test_out, 3 fz_L, 4 bist_end, 5 pass_nfail
   typedef struct {
      int unsigned cyc;
      logic [5:0]  mask;
      logic [4:0]  ra;
      logic        lk;
      logic [1:0]  to;
      logic        fz;
      logic        be;
      logic        pn;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // functional reference state
   int m_ra = 0;
   int m_lk = 0;
   int m_to = 0;

   // BIST reference results
   int sig_ok, sig_dut, fin_ra, fin_lk, fin_to, dummy_ra, dummy_lk, dummy_to;
   logic exp_pass;

   function automatic void push(input int unsigned c, input logic [5:0] mask, input int ra,
                                input int lk, input int to, input logic fz, input logic be,
                                input logic pn, input string tag);
      exp_t e;
      e.cyc = c; e.mask = mask; e.ra = 5'(ra); e.lk = lk[0]; e.to = 2'(to);
      e.fz = fz; e.be = be; e.pn = pn; e.tag = tag;
      sb.push_back(e);
   endfunction

   // Whole-run model: chain held as an 8-entry bit array, LFSR/MISR as plain integers.
   function automatic void bist_model(input bit fault, output int sig, output int ra_f,
                                      output int lk_f, output int to_f);
      int ch[8];
      int l, m, ra, lk, to, fz, word, si, sv, dvv, li, ti, to_n, fb;
      bit capture;
      for (int i = 0; i < 8; i++) ch[i] = 0;
      l = 1;
      m = 0;
      for (int c = 0; c < int'(TOTAL); c++) begin
         capture = (c < int'(9 * N)) && (c % 9 == 8);
         si  = (l >> 7) & 1;
         sv  = l & 1;
         dvv = (l >> 1) & 1;
         li  = (l >> 2) & 1;
         ti  = (l >> 3) & 3;
         ra  = ch[0] + 2 * ch[1] + 4 * ch[2] + 8 * ch[3] + 16 * ch[4];
         lk  = fault ? 0 : ch[5];
         to  = ch[6] + 2 * ch[7];
         fz  = (dvv == 1 && ra == 0) ? 0 : 1;
         word = to + (ra << 2) + (lk << 7) + (fz << 8) + (ch[7] << 9);
         m = ((m << 1) & 'hFFFF) ^ (((m >> 15) & 1) != 0 ? 'h1021 : 0) ^ word;
         if (capture) begin
            to_n = ti ^ ((((ra >> 4) & 1) << 1) | (ra & 1));
            if (dvv == 1) ra = (sv == 1) ? (ra + 1) % 32 : (ra + 31) % 32;
            ch[5] = ch[5] ^ li;
            for (int i = 0; i < 5; i++) ch[i] = (ra >> i) & 1;
            ch[6] = to_n & 1;
            ch[7] = (to_n >> 1) & 1;
         end else begin
            ch[7] = ch[6];
            ch[6] = lk;
            ch[5] = ch[4];
            for (int i = 4; i > 0; i--) ch[i] = ch[i - 1];
            ch[0] = si;
         end
         fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
         l  = ((l << 1) & 'hFF) | fb;
      end
      sig  = m;
      ra_f = ch[0] + 2 * ch[1] + 4 * ch[2] + 8 * ch[3] + 16 * ch[4];
      lk_f = fault ? 0 : ch[5];
      to_f = ch[6] + 2 * ch[7];
   endfunction

   task automatic drive(input logic rst, input logic st, input logic s_i, input logic dv_i,
                        input logic l_i, input logic [1:0] t_i);
      @(posedge clock);
      #7;
      reset = rst; bist_start = st; s = s_i; dv = dv_i; l_in = l_i; test_in = t_i;
   endtask

   task automatic fstep(input logic s_i, input logic dv_i, input logic l_i,
                        input logic [1:0] t_i, input string tag);
      drive(1'b1, 1'b0, s_i, dv_i, l_i, t_i);
      m_to = int'(t_i) ^ ((((m_ra >> 4) & 1) << 1) | (m_ra & 1));
      if (dv_i) m_ra = s_i ? (m_ra + 1) % 32 : (m_ra + 31) % 32;
      m_lk = m_lk ^ int'(l_i);
      push(cyc + 1, 6'b111111, m_ra, FAULT ? 0 : m_lk, m_to, !(dv_i && m_ra == 0),
           1'b0, 1'b0, tag);
   endtask

   task automatic run_bist(input int unsigned abort_at, input string tag);
      int unsigned c0;
      drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      c0 = cyc + 1;
      for (int unsigned k = 0; k < TOTAL + 7; k++) begin
         if (k <= TOTAL)
            push(c0 + k, 6'b110000, 0, 0, 0, 1'b1, 1'b0, 1'b0, {tag, "_running"});
         else if (k == TOTAL + 1)
            push(c0 + k, 6'b110111, fin_ra, fin_lk, fin_to, 1'b1, 1'b1, exp_pass,
                 {tag, "_end"});
         else
            push(c0 + k, 6'b110000, 0, 0, 0, 1'b1, 1'b1, exp_pass, {tag, "_hold"});
         if (abort_at != 0 && k + 1 == abort_at) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
            push(cyc + 1, 6'b111111, 0, 0, 0, 1'b1, 1'b0, 1'b0, {tag, "_abort"});
            return;
         end
         drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(negedge clock);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            bad = 1'b0;
            if (e.mask[0] && cut_read_a   !== e.ra) bad = 1'b1;
            if (e.mask[1] && cut_lclk     !== e.lk) bad = 1'b1;
            if (e.mask[2] && cut_test_out !== e.to) bad = 1'b1;
            if (e.mask[3] && cut_fz_L     !== e.fz) bad = 1'b1;
            if (e.mask[4] && bist_end     !== e.be) bad = 1'b1;
            if (e.mask[5] && pass_nfail   !== e.pn) bad = 1'b1;
            vectors++;
            if (bad) begin
               miscompares++;
               $display("FAIL %s cyc=%0d mask=%b got ra=%0d lclk=%b to=%b fz=%b end=%b pass=%b want ra=%0d lclk=%b to=%b fz=%b end=%b pass=%b",
                        e.tag, e.cyc, e.mask, cut_read_a, cut_lclk, cut_test_out, cut_fz_L,
                        bist_end, pass_nfail, e.ra, e.lk, e.to, e.fz, e.be, e.pn);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d pending=%0d", cyc, sb.size());
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; bist_start = 1'b0; s = 1'b0; dv = 1'b0; l_in = 1'b0; test_in = 2'b00;
      bist_model(1'b0, sig_ok, dummy_ra, dummy_lk, dummy_to);
      bist_model(FAULT, sig_dut, fin_ra, fin_lk, fin_to);
      exp_pass = (sig_dut == sig_ok);

      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
         push(cyc + 1, 6'b111111, 0, 0, 0, 1'b1, 1'b0, 1'b0, "reset");
      end

      for (int i = 0; i < 33; i++) fstep(1'b1, 1'b1, 1'($urandom), 2'($urandom), "count_up");
      for (int i = 0; i < 2; i++)  fstep(1'b0, 1'b1, 1'($urandom), 2'($urandom), "count_down");
      for (int i = 0; i < 18; i++) fstep(1'b1, 1'b1, 1'b0, 2'($urandom), "to_17");
      fstep(1'b0, 1'b0, 1'b0, 2'b11, "test_out_xor");
      for (int i = 0; i < 3; i++)  fstep(1'b0, 1'b0, 1'b1, 2'b00, "lclk_toggle");
      for (int i = 0; i < 40; i++)
         fstep(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), "func_rand");
      fstep(1'b0, 1'b0, 1'b0, 2'b00, "idle_gap");

      run_bist(0, "run1");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      run_bist(0, "run2");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      run_bist(100, "run3");
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      push(cyc + 1, 6'b111111, 0, 0, 0, 1'b1, 1'b0, 1'b0, "reset_hold");
      run_bist(0, "run4");

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
      @(negedge clock);
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain pending=%0d want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
